// File: rtl/mac_fifo_sched.sv
// mac_fifo_sched: sequencer for the MAC/FIFO matrix-vector datapath.
// On start it reads 9 memory rows of 64 bits. Row 0 is written byte-wise into
// the B FIFO and rows 1..8 into A FIFOs 0..7. It then runs 8 dot products of
// 8 terms each through the shared MAC. B bytes are recirculated into the B
// FIFO as they are consumed, and each 24-bit result is strobed out with its
// row index.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start/busy/done     run request and status
//   mem_*               Avalon-style row read interface
//   fifo_aclr, fifo_wdata, b_/a_wrreq, b_/a_rdreq, *_full, *_empty, *_q
//                       control and status of the B FIFO and the 8 A FIFOs
//   mac_en/clr/ain/bin, mac_cout   MAC control and accumulator readback
//   res_valid/idx/data  one-cycle result strobe
module mac_fifo_sched #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned MAC_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic [63:0] mem_readdata,
  input  logic        mem_readdatavalid,
  input  logic        mem_waitrequest,
  output logic        fifo_aclr,
  output logic [7:0]  fifo_wdata,
  output logic        b_wrreq,
  output logic [7:0]  a_wrreq,
  input  logic        b_full,
  input  logic [7:0]  a_full,
  output logic        b_rdreq,
  output logic [7:0]  a_rdreq,
  input  logic [7:0]  b_q,
  input  logic [63:0] a_q,
  input  logic        b_empty,
  input  logic [7:0]  a_empty,
  output logic        mac_en,
  output logic        mac_clr,
  output logic [7:0]  mac_ain,
  output logic [7:0]  mac_bin,
  input  logic [23:0] mac_cout,
  output logic        res_valid,
  output logic [2:0]  res_idx,
  output logic [23:0] res_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_REQ, S_WAITD, S_FILL, S_COMP, S_DRAIN, S_CAPTURE, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  row_cnt_q, row_cnt_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]  i_q, i_d;
  logic [3:0]  j_q, j_d;
  logic        issue_q, issue_d;
  logic [63:0] rowbuf_q, rowbuf_d;
  logic [15:0] wait_q, wait_d;

  logic [2:0]  a_tgt;
  logic [2:0]  byte_sel;
  logic        tgt_full;

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    byte_cnt_d = byte_cnt_q;
    i_d        = i_q;
    j_d        = j_q;
    issue_d    = issue_q;
    rowbuf_d   = rowbuf_q;
    wait_d     = wait_q;

    mem_address = '0;
    mem_read    = 1'b0;
    fifo_aclr   = 1'b0;
    fifo_wdata  = '0;
    b_wrreq     = 1'b0;
    a_wrreq     = '0;
    b_rdreq     = 1'b0;
    a_rdreq     = '0;
    mac_en      = 1'b0;
    mac_clr     = 1'b0;
    mac_ain     = '0;
    mac_bin     = '0;
    res_valid   = 1'b0;
    res_idx     = '0;
    res_data    = '0;

    // Row 0 targets B; row r targets A[r-1] (row 8 wraps to index 7).
    a_tgt    = row_cnt_q[2:0] - 3'd1;
    byte_sel = 3'd7 - byte_cnt_q;
    tgt_full = (row_cnt_q == 4'd0) ? b_full : a_full[a_tgt];

    busy = (state_q != S_IDLE) && (state_q != S_DONE);
    done = (state_q == S_DONE);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        fifo_aclr = 1'b1;
        mac_clr   = 1'b1;
        row_cnt_d = '0;
        state_d   = S_REQ;
      end
      S_REQ: begin
        mem_read    = 1'b1;
        mem_address = BASE_ADDR + {28'd0, row_cnt_q};
        if (!mem_waitrequest) state_d = S_WAITD;
      end
      S_WAITD: begin
        if (mem_readdatavalid) begin
          rowbuf_d   = mem_readdata;
          byte_cnt_d = '0;
          state_d    = S_FILL;
        end
      end
      S_FILL: begin
        // Byte k of the row sits at bits [63-8k:56-8k].
        fifo_wdata = rowbuf_q[{byte_sel, 3'b000} +: 8];
        if (!tgt_full) begin
          if (row_cnt_q == 4'd0) b_wrreq = 1'b1;
          else                   a_wrreq[a_tgt] = 1'b1;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd7) begin
            row_cnt_d = row_cnt_q + 4'd1;
            if (row_cnt_q == 4'd8) begin
              state_d = S_COMP;
              i_d     = '0;
              j_d     = '0;
              issue_d = 1'b0;
            end else begin
              state_d = S_REQ;
            end
          end
        end
      end
      S_COMP: begin
        // Pop in one cycle, issue to the MAC the next (non-showahead q).
        if (issue_q) begin
          mac_en     = 1'b1;
          mac_ain    = a_q[{i_q, 3'b000} +: 8];
          mac_bin    = b_q;
          b_wrreq    = 1'b1;
          fifo_wdata = b_q;
        end
        issue_d = 1'b0;
        if ((j_q < 4'd8) && !a_empty[i_q] && !b_empty) begin
          a_rdreq[i_q] = 1'b1;
          b_rdreq      = 1'b1;
          j_d          = j_q + 4'd1;
          issue_d      = 1'b1;
        end
        if (issue_q && (j_q == 4'd8)) begin
          if (MAC_LAT <= 1) begin
            state_d = S_CAPTURE;
          end else begin
            wait_d  = 16'(MAC_LAT - 1);
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        wait_d = wait_q - 16'd1;
        if (wait_q <= 16'd1) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        res_valid = 1'b1;
        res_data  = mac_cout;
        res_idx   = i_q;
        mac_clr   = 1'b1;
        i_d       = i_q + 3'd1;
        j_d       = '0;
        state_d   = (i_q == 3'd7) ? S_DONE : S_COMP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_cnt_q  <= '0;
      byte_cnt_q <= '0;
      i_q        <= '0;
      j_q        <= '0;
      issue_q    <= 1'b0;
      rowbuf_q   <= '0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      i_q        <= i_d;
      j_q        <= j_d;
      issue_q    <= issue_d;
      rowbuf_q   <= rowbuf_d;
      wait_q     <= wait_d;
    end
  end

endmodule

// File: tb/tb_mac_fifo_sched.sv
module tb_mac_fifo_sched;
  localparam logic [31:0] BASE = 32'd16;
  localparam int unsigned LAT  = 2;
  localparam int M_PLAIN = 0, M_IDENT = 1, M_ONES = 2, M_BP = 3, M_BUSY = 4;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        busy, done, mem_read, mem_readdatavalid, mem_waitrequest;
  logic [31:0] mem_address;
  logic [63:0] mem_readdata;
  logic        fifo_aclr, b_wrreq, b_full, b_rdreq, b_empty;
  logic [7:0]  fifo_wdata, a_wrreq, a_full, a_rdreq, a_empty, b_q;
  logic [63:0] a_q;
  logic        mac_en, mac_clr, res_valid;
  logic [7:0]  mac_ain, mac_bin;
  logic [23:0] mac_cout, res_data;
  logic [2:0]  res_idx;

  mac_fifo_sched #(.BASE_ADDR(BASE), .MAC_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
    .fifo_aclr(fifo_aclr), .fifo_wdata(fifo_wdata), .b_wrreq(b_wrreq), .a_wrreq(a_wrreq),
    .b_full(b_full), .a_full(a_full), .b_rdreq(b_rdreq), .a_rdreq(a_rdreq),
    .b_q(b_q), .a_q(a_q), .b_empty(b_empty), .a_empty(a_empty),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_ain(mac_ain), .mac_bin(mac_bin),
    .mac_cout(mac_cout), .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // ---------------- memory model: stall wait_len cycles, data 2 cycles after accept
  logic [63:0] mem [0:8];
  int          wait_len = 0;
  int          rd_age = 0;
  int          accepts = 0;
  logic        rd_pend = 1'b0;
  int          rd_idx = 0;

  assign mem_waitrequest = mem_read && (rd_age < wait_len);

  always @(posedge clk) begin
    mem_readdatavalid <= 1'b0;
    if (rd_pend) begin
      mem_readdatavalid <= 1'b1;
      mem_readdata      <= mem[rd_idx];
      rd_pend           <= 1'b0;
    end
    if (mem_read) begin
      if (mem_waitrequest) rd_age <= rd_age + 1;
      else begin
        rd_pend <= 1'b1;
        rd_idx  <= int'(mem_address - BASE);
        accepts <= accepts + 1;
        rd_age  <= 0;
      end
    end else begin
      rd_age <= 0;
    end
  end

  // ---------------- MAC model, latency 2
  logic        en_p = 1'b0;
  logic [7:0]  a_p = '0, b_p = '0;
  logic [23:0] acc = '0;
  always @(posedge clk) begin
    en_p <= mac_en;
    a_p  <= mac_ain;
    b_p  <= mac_bin;
    if (mac_clr)   acc <= '0;
    else if (en_p) acc <= acc + 24'(a_p) * 24'(b_p);
  end
  assign mac_cout = acc;

  // ---------------- FIFO models: index 0 = B, k+1 = A[k]; depth 16, non-showahead
  logic [7:0] fmem [9][16];
  int         fcnt [9];
  int         fwp  [9];
  int         frp  [9];
  logic [7:0] fq   [9];
  logic [8:0] force_full;
  logic [7:0] a2_log [16];
  int         a2_n = 0;

  initial for (int k = 0; k < 9; k++) begin fcnt[k] = 0; fwp[k] = 0; frp[k] = 0; fq[k] = '0; end

  always @(posedge clk) begin
    bit wr, rd;
    if (fifo_aclr) begin
      for (int k = 0; k < 9; k++) begin fcnt[k] <= 0; fwp[k] <= 0; frp[k] <= 0; end
      a2_n <= 0;
    end else begin
      for (int k = 0; k < 9; k++) begin
        wr = (k == 0) ? b_wrreq : a_wrreq[k-1];
        rd = (k == 0) ? b_rdreq : a_rdreq[k-1];
        if (rd) begin fq[k] <= fmem[k][frp[k]]; frp[k] <= (frp[k] + 1) % 16; end
        if (wr) begin fmem[k][fwp[k]] <= fifo_wdata; fwp[k] <= (fwp[k] + 1) % 16; end
        fcnt[k] <= fcnt[k] + (wr ? 1 : 0) - (rd ? 1 : 0);
      end
      if (a_wrreq[2] && a2_n < 16) begin a2_log[a2_n] <= fifo_wdata; a2_n <= a2_n + 1; end
    end
  end

  always_comb begin
    b_q     = fq[0];
    b_empty = (fcnt[0] == 0);
    b_full  = (fcnt[0] >= 16) || force_full[0];
    a_q     = '0;
    a_empty = '0;
    a_full  = '0;
    for (int k = 0; k < 8; k++) begin
      a_q[8*k +: 8] = fq[k+1];
      a_empty[k]    = (fcnt[k+1] == 0);
      a_full[k]     = (fcnt[k+1] >= 16) || force_full[k+1];
    end
  end

  // ---------------- checking
  int          checks = 0, errors = 0;
  logic [23:0] expv [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [63:0] row, input int k);
    return row[63-8*k -: 8];
  endfunction

  // Dot product of A row (memory row i+1) with B (memory row 0).
  task automatic compute_exp();
    int s;
    for (int i = 0; i < 8; i++) begin
      s = 0;
      for (int k = 0; k < 8; k++) s += int'(byte_of(mem[i+1], k)) * int'(byte_of(mem[0], k));
      expv[i] = 24'(s);
    end
  endtask

  task automatic load_ident();
    mem[0] = 64'h0102030405060708;
    for (int r = 1; r < 9; r++) mem[r] = 64'h1 << (64 - 8*r);
  endtask

  task automatic load_pattern(input int seed);
    for (int r = 0; r < 9; r++)
      for (int k = 0; k < 8; k++) mem[r][63-8*k -: 8] = 8'((r*37 + k*11 + seed) & 255);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_ctrl"}, {36'd0, busy, done, mem_read, fifo_aclr, b_wrreq, a_wrreq, b_rdreq,
                        a_rdreq, mac_en, mac_clr, res_valid, res_idx}, 64'd0);
    chk({nm, "_addr_res"}, {8'd0, mem_address, res_data}, 64'd0);
    chk({nm, "_data"}, {40'd0, fifo_wdata, mac_ain, mac_bin}, 64'd0);
  endtask

  // Runs one sequence; returns early after stop_idx results when stop_idx < 8.
  task automatic run(input int mode, input int stop_idx);
    int   cyc, n_res, acc0, force_left;
    bit   forced, started2, prev_stall;
    logic [31:0] prev_addr;
    compute_exp();
    acc0 = accepts; n_res = 0; cyc = 0; force_left = 0;
    forced = 0; started2 = 0; prev_stall = 0; prev_addr = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("clear_aclr", {62'd0, fifo_aclr, mac_clr}, 64'd3);
    chk("clear_busy_done", {62'd0, busy, done}, 64'd2);
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (res_valid) begin
        chk("res_idx", 64'(res_idx), 64'(n_res));
        chk("res_data", 64'(res_data), 64'(expv[n_res]));
        if (mode == M_IDENT) chk("res_ident_lit", 64'(res_data), 64'(n_res + 1));
        if (mode == M_ONES)  chk("res_ones_lit", 64'(res_data), 64'd520200);
        n_res++;
        if (stop_idx < 8 && n_res == stop_idx) return;
      end
      if (|a_wrreq) chk("a_wrreq_onehot", 64'($countones(a_wrreq)), 64'd1);
      if (|a_rdreq) chk("a_rdreq_onehot", 64'($countones(a_rdreq)), 64'd1);
      if (prev_stall) chk("req_stable", {31'd0, mem_read, mem_address}, {31'd0, 1'b1, prev_addr});
      if (mem_read && !mem_waitrequest)
        chk("accept_addr", 64'(mem_address), 64'(BASE + 32'(accepts - acc0)));
      prev_stall = mem_read && mem_waitrequest;
      prev_addr  = mem_address;
      if (force_left > 0) begin
        chk("a2_stalled", 64'(a_wrreq[2]), 64'd0);
        force_left--;
        if (force_left == 0) begin
          chk("a2_frozen", 64'(a2_n), 64'd3);
          force_full = '0;
        end
      end else if (mode == M_BP && !forced && a2_n == 3) begin
        force_full[3] = 1'b1;
        forced = 1;
        force_left = 4;
      end
      if (mode == M_BUSY && !started2 && b_wrreq && !mac_en) begin
        chk("busy_at_restart", 64'(busy), 64'd1);
        start = 1'b1;
        started2 = 1;
      end
    end
    start = 1'b0;
    force_full = '0;
    chk("run_done", 64'(done), 64'd1);
    chk("run_busy_low", 64'(busy), 64'd0);
    chk("run_results", 64'(n_res), 64'd8);
    chk("run_accepts", 64'(accepts - acc0), 64'd9);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; force_full = '0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Identity
    load_ident();
    run(M_IDENT, 8);
    repeat (3) @(negedge clk);
    chk("done_held", {62'd0, done, busy}, 64'd2);

    // All ones
    for (int r = 0; r < 9; r++) mem[r] = '1;
    run(M_ONES, 8);

    // Memory stall of 5 cycles per request
    wait_len = 5;
    load_ident();
    run(M_IDENT, 8);
    wait_len = 0;

    // Fill backpressure on A2 (row 3)
    load_pattern(3);
    run(M_BP, 8);
    chk("a2_count", 64'(a2_n), 64'd8);
    for (int k = 0; k < 8; k++) chk("a2_order", 64'(a2_log[k]), 64'(byte_of(mem[3], k)));

    // Reset during COMP of row 4, then a clean rerun on different data
    load_pattern(77);
    run(M_PLAIN, 4);
    @(negedge clk);
    chk("busy_before_rst", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    load_pattern(150);
    run(M_PLAIN, 8);

    // Start while busy is ignored; a start after done reruns
    load_pattern(201);
    run(M_BUSY, 8);
    run(M_PLAIN, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
